if_id_pl_reg: RTL and testbench

IF_ID_PL_REG -- requirements
Module: if_id_pl_reg

---
 rtl/if_id_pkg.sv | 11 +
 rtl/pl_stage_reg.sv | 32 +++
 rtl/if_id_pl_reg.sv | 71 +++++++
 tb/tb_if_id_pl_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared constants for the IF/ID pipeline register slice.
//   DATA_W_DEF    : default width of the instruction and PC fields
//   NOP_INSTR_DEF : default instruction injected when the slot is squashed
//   BUBBLE_PC     : PC value presented while the slot holds a bubble
package if_id_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;
  localparam int unsigned BUBBLE_PC = 0;

endpackage : if_id_pkg

// File: rtl/pl_stage_reg.sv
// Generic pipeline stage register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RST_VAL
//   hold  : keep current contents (lower priority than clr)
//   clr   : synchronous clear, loads CLR_VAL
//   d     : next contents when neither hold nor clr is active
//   q     : registered contents
module pl_stage_reg #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule : pl_stage_reg

// File: rtl/if_id_pl_reg.sv
// IF/ID pipeline register: carries the fetched instruction and its PC into
// the decode stage, with stall (freeze) and squash (flush) control.
// Ports:
//   clk             : rising-edge clock
//   rst             : asynchronous active-low reset, forces a bubble
//   freeze          : hold current contents
//   flush           : replace contents with a bubble (wins over freeze)
//   instruction_in  : fetched instruction from IF
//   pc_in           : PC of instruction_in
//   instruction_out : registered instruction to ID (NOP_INSTR when bubble)
//   pc_out          : registered PC to ID (0 when bubble)
//   valid_out       : 1 = real instruction, 0 = bubble/reset
// Build option: define IF_ID_PL_REG_ASSERT_EN to compile simulation-only
// X/Z checks on the control and (when loading) data inputs.
module if_id_pl_reg
  import if_id_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [DATA_W-1:0] instruction_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] instruction_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              valid_out
);

  localparam int unsigned BW = 2 * DATA_W + 1;
  localparam logic [BW-1:0] BUBBLE = {1'b0, DATA_W'(BUBBLE_PC), NOP_INSTR};

  logic [BW-1:0] bundle_d;
  logic [BW-1:0] bundle_q;

  assign bundle_d = {1'b1, pc_in, instruction_in};

  // Reset and flush share the bubble encoding, so one stage register with
  // identical reset and clear values covers both.
  pl_stage_reg #(
    .W      (BW),
    .RST_VAL(BUBBLE),
    .CLR_VAL(BUBBLE)
  ) u_stage (
    .clk  (clk),
    .rst_n(rst),
    .hold (freeze),
    .clr  (flush),
    .d    (bundle_d),
    .q    (bundle_q)
  );

  assign {valid_out, pc_out, instruction_out} = bundle_q;

`ifdef IF_ID_PL_REG_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst === 1'b1) begin
      if ($isunknown(freeze) || $isunknown(flush)) begin
        $error("if_id_pl_reg: X/Z on freeze/flush (freeze=%b flush=%b)", freeze, flush);
      end
      if (flush === 1'b0 && freeze === 1'b0 &&
          ($isunknown(instruction_in) || $isunknown(pc_in))) begin
        $error("if_id_pl_reg: X/Z on load data (instr=%h pc=%h)", instruction_in, pc_in);
      end
    end
  end
`endif

endmodule : if_id_pl_reg

// File: tb/tb_if_id_pl_reg.sv
module tb_if_id_pl_reg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] NOP = 16'h0000;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] pc;
    logic [DW-1:0] ins;
  } slot_t;

  localparam slot_t BUBBLE_SLOT = '{v: 1'b0, pc: '0, ins: NOP};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] instruction_in = '0;
  logic [DW-1:0] pc_in = '0;
  logic [DW-1:0] instruction_out;
  logic [DW-1:0] pc_out;
  logic          valid_out;

  slot_t exp_q[$];
  slot_t mdl;          // what the decode stage should currently be seeing
  int    total = 0;
  int    bad   = 0;
  event  chk;

  always #5 clk = ~clk;

  if_id_pl_reg #(
    .DATA_W   (DW),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .instruction_in (instruction_in),
    .pc_in          (pc_in),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
  );

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    slot_t e;
    forever begin
      @chk;
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: got check request with empty queue");
      end else begin
        e = exp_q.pop_front();
        if (valid_out !== e.v || pc_out !== e.pc || instruction_out !== e.ins) begin
          bad++;
          $display("FAIL slot @%0t: got v=%b pc=%h ins=%h, want v=%b pc=%h ins=%h",
                   $time, valid_out, pc_out, instruction_out, e.v, e.pc, e.ins);
        end
      end
    end
  end

  task automatic expect_now();
    exp_q.push_back(mdl);
    ->chk;
  endtask

  // Reference behaviour at a rising edge: reset or squash gives a bubble,
  // a stall keeps what decode already has, otherwise fetch output moves in.
  task automatic edge_update();
    @(posedge clk);
    if (!rst || flush)   mdl = BUBBLE_SLOT;
    else if (!freeze)    mdl = '{v: 1'b1, pc: pc_in, ins: instruction_in};
    expect_now();
  endtask

  task automatic cyc(input logic [DW-1:0] ins, input logic [DW-1:0] pc,
                     input logic frz, input logic fl, input bit glitch);
    @(negedge clk);
    instruction_in = ins;
    pc_in          = pc;
    freeze         = frz;
    flush          = fl;
    edge_update();
    if (glitch) begin
      // inputs wander between edges; outputs must not move
      #3;
      instruction_in = 16'($urandom);
      pc_in          = 16'($urandom);
      freeze         = 1'($urandom);
      flush          = 1'($urandom);
      expect_now();
    end
  endtask

  // Called right after a non-glitch cyc (at the rising edge).
  task automatic async_rst();
    #2;
    rst = 1'b0;
    mdl = BUBBLE_SLOT;
    expect_now();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl = BUBBLE_SLOT;
    #2;
    expect_now();                 // bubble before any edge

    cyc(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);   // held in reset
    cyc(16'hbeef, 16'hcafe, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    cyc(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1);
    cyc(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(16'h0009, 16'h0009, 1'b1, 1'b0, 1'b1);
    cyc(16'h0004, 16'h0006, 1'b0, 1'b1, 1'b0);
    cyc(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    cyc(16'h000a, 16'h000b, 1'b0, 1'b0, 1'b0);
    cyc(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
    cyc(16'h0008, 16'h0008, 1'b1, 1'b1, 1'b0);
    cyc(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0);
    async_rst();
    cyc(16'h000c, 16'h000d, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      bit g;
      g = ($urandom_range(3) == 0);
      cyc(16'($urandom), 16'($urandom),
          ($urandom_range(3) == 0), ($urandom_range(4) == 0), g);
      if (!g && $urandom_range(29) == 0) async_rst();
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_pl_reg
